// File: rtl/frame_cfg_sched.sv
// frame_cfg_sched: applies a CPU config set (h_info, v_info, hscale) to the scanconverter.
// A new set is taken only on an input frame boundary. Output is then blanked for FRAME_MUTE
// VSYNC edges. The block also measures input lines per frame and reports frame stability.
//
// Ports (all in the PCLK_in domain except cfg_req_tgl):
//   PCLK_in, reset_n             pixel clock, async active-low reset
//   HSYNC_in, VSYNC_in           latched input syncs, active-low
//   cfg_req_tgl                  request toggle from the clk27 domain (synchronized here)
//   h_info_new/v_info_new/hscale_new  pending config, quasi-static while a request is open
//   cfg_ack_tgl                  toggles once per applied request
//   h_info_o/v_info_o/hscale_o   applied config
//   blank_o                      force output blanking
//   lines_meas                   line count of the last complete frame (saturates at 2047)
//   frame_stable                 STABLE_FRAMES consecutive frames within LINE_TOL
//
// Optional feature: define FRAME_CFG_UNSTABLE_BLANK_EN to also blank whenever frame_stable
// is low. Without it, blank_o is driven by the FSM only.

module frame_cfg_sched #(
  parameter int unsigned FRAME_MUTE    = 2,
  parameter int unsigned STABLE_FRAMES = 4,
  parameter int unsigned LINE_TOL      = 1
) (
  input  logic        PCLK_in,
  input  logic        reset_n,
  input  logic        HSYNC_in,
  input  logic        VSYNC_in,
  input  logic        cfg_req_tgl,
  input  logic [31:0] h_info_new,
  input  logic [31:0] v_info_new,
  input  logic [31:0] hscale_new,
  output logic        cfg_ack_tgl,
  output logic [31:0] h_info_o,
  output logic [31:0] v_info_o,
  output logic [31:0] hscale_o,
  output logic        blank_o,
  output logic [10:0] lines_meas,
  output logic        frame_stable
);

  localparam logic [3:0]  MuteLim = 4'(FRAME_MUTE);
  localparam logic [3:0]  StabLim = 4'(STABLE_FRAMES);
  localparam logic [11:0] LineTol = 12'(LINE_TOL);
  localparam logic [10:0] LineMax = 11'h7FF;

  typedef enum logic [1:0] {StIdle, StPend, StApply, StMute} state_e;

  // Request synchronizer and sync edge detectors
  logic r_req_s1, r_req_s2, r_req_s3;
  logic r_vs_d, r_hs_d;
  logic w_req_evt, w_vs_evt, w_hs_evt;

  always_ff @(posedge PCLK_in or negedge reset_n) begin
    if (!reset_n) begin
      r_req_s1 <= 1'b0;
      r_req_s2 <= 1'b0;
      r_req_s3 <= 1'b0;
      r_vs_d   <= 1'b1;
      r_hs_d   <= 1'b1;
    end else begin
      r_req_s1 <= cfg_req_tgl;
      r_req_s2 <= r_req_s1;
      r_req_s3 <= r_req_s2;
      r_vs_d   <= VSYNC_in;
      r_hs_d   <= HSYNC_in;
    end
  end

  assign w_req_evt = r_req_s2 ^ r_req_s3;
  assign w_vs_evt  = r_vs_d & ~VSYNC_in;
  assign w_hs_evt  = r_hs_d & ~HSYNC_in;

  // Config apply FSM
  state_e      r_state;
  logic [3:0]  r_mute_cnt;
  logic [3:0]  w_mute_inc;
  logic        r_req_pend;
  logic        r_blank;
  logic        r_ack;
  logic [31:0] r_h_info, r_v_info, r_hscale;

  assign w_mute_inc = r_mute_cnt + 4'd1;

  always_ff @(posedge PCLK_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_mute_cnt <= 4'd0;
      r_req_pend <= 1'b0;
      r_blank    <= 1'b1;
      r_ack      <= 1'b0;
      r_h_info   <= 32'd0;
      r_v_info   <= 32'd0;
      r_hscale   <= 32'd0;
    end else begin
      case (r_state)
        // A vs_evt coinciding with the request is deliberately not used.
        StIdle: begin
          if (w_req_evt) r_state <= StPend;
        end
        // Extra requests here are covered by the apply that is about to happen.
        StPend: begin
          if (w_vs_evt) r_state <= StApply;
        end
        StApply: begin
          r_h_info   <= h_info_new;
          r_v_info   <= v_info_new;
          r_hscale   <= hscale_new;
          r_ack      <= ~r_ack;
          r_blank    <= 1'b1;
          r_mute_cnt <= 4'd0;
          // The new buses were sampled this cycle; a request arriving now needs its own apply.
          r_req_pend <= w_req_evt;
          r_state    <= StMute;
        end
        StMute: begin
          if (w_req_evt) r_req_pend <= 1'b1;
          if (w_vs_evt) begin
            r_mute_cnt <= w_mute_inc;
            if (w_mute_inc == MuteLim) begin
              r_blank    <= 1'b0;
              r_req_pend <= 1'b0;
              r_state    <= (r_req_pend || w_req_evt) ? StPend : StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Line counter and stability tracking
  logic [10:0] r_line_cnt;
  logic [10:0] r_lines_meas;
  logic [3:0]  r_stab_cnt;
  logic        r_frame_stable;
  logic [11:0] w_diff;
  logic        w_match;
  logic [3:0]  w_stab_nxt;

  always_comb begin
    w_diff = 12'd0;
    if (r_line_cnt >= r_lines_meas) begin
      w_diff = {1'b0, r_line_cnt} - {1'b0, r_lines_meas};
    end else begin
      w_diff = {1'b0, r_lines_meas} - {1'b0, r_line_cnt};
    end
  end

  // A saturated count or an empty previous frame never counts as a match.
  assign w_match = (w_diff <= LineTol) && (r_line_cnt != LineMax) && (r_lines_meas != 11'd0);

  always_comb begin
    w_stab_nxt = 4'd0;
    if (w_match) begin
      w_stab_nxt = (r_stab_cnt == StabLim) ? r_stab_cnt : r_stab_cnt + 4'd1;
    end
  end

  always_ff @(posedge PCLK_in or negedge reset_n) begin
    if (!reset_n) begin
      r_line_cnt     <= 11'd0;
      r_lines_meas   <= 11'd0;
      r_stab_cnt     <= 4'd0;
      r_frame_stable <= 1'b0;
    end else if (w_vs_evt) begin
      r_lines_meas   <= r_line_cnt;
      // An hsync edge in the same cycle as vsync is the first line of the new frame.
      r_line_cnt     <= w_hs_evt ? 11'd1 : 11'd0;
      r_stab_cnt     <= w_stab_nxt;
      r_frame_stable <= (w_stab_nxt == StabLim);
    end else if (w_hs_evt && (r_line_cnt != LineMax)) begin
      r_line_cnt <= r_line_cnt + 11'd1;
    end
  end

  assign cfg_ack_tgl  = r_ack;
  assign h_info_o     = r_h_info;
  assign v_info_o     = r_v_info;
  assign hscale_o     = r_hscale;
  assign lines_meas   = r_lines_meas;
  assign frame_stable = r_frame_stable;

`ifdef FRAME_CFG_UNSTABLE_BLANK_EN
  assign blank_o = r_blank | ~r_frame_stable;
`else
  assign blank_o = r_blank;
`endif

endmodule

// File: tb/tb_frame_cfg_sched.sv
// Directed bench for frame_cfg_sched: lock-in, config apply and mute, request coalescing,
// line tolerance, line-count saturation and reset while a request is pending.

module tb_frame_cfg_sched;

  logic        PCLK_in = 1'b0;
  logic        reset_n = 1'b0;
  logic        HSYNC_in = 1'b1;
  logic        VSYNC_in = 1'b1;
  logic        cfg_req_tgl = 1'b0;
  logic [31:0] h_info_new = 32'd0;
  logic [31:0] v_info_new = 32'd0;
  logic [31:0] hscale_new = 32'd0;
  logic        cfg_ack_tgl;
  logic [31:0] h_info_o, v_info_o, hscale_o;
  logic        blank_o;
  logic [10:0] lines_meas;
  logic        frame_stable;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_ack  = 1'b0;

`ifdef FRAME_CFG_UNSTABLE_BLANK_EN
  localparam bit UnstableBlank = 1'b1;
`else
  localparam bit UnstableBlank = 1'b0;
`endif

  frame_cfg_sched u_dut (
    .PCLK_in      (PCLK_in),
    .reset_n      (reset_n),
    .HSYNC_in     (HSYNC_in),
    .VSYNC_in     (VSYNC_in),
    .cfg_req_tgl  (cfg_req_tgl),
    .h_info_new   (h_info_new),
    .v_info_new   (v_info_new),
    .hscale_new   (hscale_new),
    .cfg_ack_tgl  (cfg_ack_tgl),
    .h_info_o     (h_info_o),
    .v_info_o     (v_info_o),
    .hscale_o     (hscale_o),
    .blank_o      (blank_o),
    .lines_meas   (lines_meas),
    .frame_stable (frame_stable)
  );

  always #5 PCLK_in = ~PCLK_in;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic blank_exp(input logic fsm_b, input logic fs_b);
    return fsm_b | (UnstableBlank & ~fs_b);
  endfunction

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      HSYNC_in = 1'b0;
      @(negedge PCLK_in);
      HSYNC_in = 1'b1;
      @(negedge PCLK_in);
    end
  endtask

  task automatic vsync();
    VSYNC_in = 1'b0;
    @(negedge PCLK_in);
    VSYNC_in = 1'b1;
    @(negedge PCLK_in);
  endtask

  task automatic frame(input int n);
    lines(n);
    vsync();
  endtask

  task automatic toggle_req();
    cfg_req_tgl = ~cfg_req_tgl;
    @(negedge PCLK_in);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (3) @(negedge PCLK_in);
    check_val("rst_h", h_info_o, 0);
    check_val("rst_v", v_info_o, 0);
    check_val("rst_hscale", hscale_o, 0);
    check_val("rst_blank", 32'(blank_o), 1);
    check_val("rst_ack", 32'(cfg_ack_tgl), 0);
    check_val("rst_lines", 32'(lines_meas), 0);
    check_val("rst_stable", 32'(frame_stable), 0);
    reset_n = 1'b1;
    @(negedge PCLK_in);

    // Lock-in on 262-line frames, no request
    for (int f = 1; f <= 5; f++) begin
      frame(262);
      if (f == 4) check_val("stable_f4", 32'(frame_stable), 0);
    end
    check_val("stable_f5", 32'(frame_stable), 1);
    check_val("lines_262", 32'(lines_meas), 262);
    check_val("blank_nocfg", 32'(blank_o), 1);

    // Mid-frame request, applied only after the next vsync
    h_info_new = 32'h0355_3E3C;
    v_info_new = 32'h0000_00F5;
    hscale_new = 32'h0000_0200;
    toggle_req();
    lines(100);
    check_val("h_hold_pend", h_info_o, 0);
    check_val("ack_hold_pend", 32'(cfg_ack_tgl), 0);
    lines(162);
    VSYNC_in = 1'b0;
    @(negedge PCLK_in);
    VSYNC_in = 1'b1;
    check_val("h_hold_vs", h_info_o, 0);
    @(negedge PCLK_in);
    exp_ack = ~exp_ack;
    check_val("h_apply", h_info_o, 32'h0355_3E3C);
    check_val("v_apply", v_info_o, 32'h0000_00F5);
    check_val("hscale_apply", hscale_o, 32'h0000_0200);
    check_val("ack_apply", 32'(cfg_ack_tgl), 32'(exp_ack));
    check_val("blank_apply", 32'(blank_o), 1);
    frame(262);
    check_val("blank_mute1", 32'(blank_o), 32'(blank_exp(1'b1, 1'b1)));
    frame(262);
    check_val("blank_mute2", 32'(blank_o), 32'(blank_exp(1'b0, 1'b1)));
    check_val("ack_once", 32'(cfg_ack_tgl), 32'(exp_ack));

    // Two requests during mute collapse into one further apply
    h_info_new = 32'h1111_2222;
    toggle_req();
    frame(262);
    exp_ack = ~exp_ack;
    check_val("h_apply2", h_info_o, 32'h1111_2222);
    check_val("ack_apply2", 32'(cfg_ack_tgl), 32'(exp_ack));
    lines(50);
    toggle_req();
    lines(100);
    h_info_new = 32'h3333_4444;
    toggle_req();
    lines(112);
    vsync();
    frame(262);
    check_val("blank_gap", 32'(blank_o), 32'(blank_exp(1'b0, 1'b1)));
    check_val("ack_gap", 32'(cfg_ack_tgl), 32'(exp_ack));
    check_val("h_gap", h_info_o, 32'h1111_2222);
    frame(262);
    exp_ack = ~exp_ack;
    check_val("h_apply3", h_info_o, 32'h3333_4444);
    check_val("ack_apply3", 32'(cfg_ack_tgl), 32'(exp_ack));
    check_val("blank_apply3", 32'(blank_o), 1);
    frame(262);
    frame(262);
    check_val("blank_end3", 32'(blank_o), 32'(blank_exp(1'b0, 1'b1)));
    frame(262);
    check_val("ack_single", 32'(cfg_ack_tgl), 32'(exp_ack));

    // Line tolerance: 262/264 never matches, 262/263 does
    for (int f = 0; f < 4; f++) begin
      frame((f % 2 == 0) ? 264 : 262);
      check_val("stable_alt2", 32'(frame_stable), 0);
    end
    for (int f = 0; f < 4; f++) begin
      frame((f % 2 == 0) ? 263 : 262);
      check_val("stable_alt1", 32'(frame_stable), (f == 3) ? 1 : 0);
    end
    check_val("lines_alt1", 32'(lines_meas), 262);

    // No vsync for 3000 lines: request waits, count saturates
    h_info_new = 32'h5555_6666;
    toggle_req();
    lines(3000);
    check_val("ack_no_vs", 32'(cfg_ack_tgl), 32'(exp_ack));
    check_val("h_no_vs", h_info_o, 32'h3333_4444);
    check_val("blank_no_vs", 32'(blank_o), 32'(blank_exp(1'b0, 1'b1)));
    vsync();
    exp_ack = ~exp_ack;
    check_val("lines_sat", 32'(lines_meas), 2047);
    check_val("stable_sat", 32'(frame_stable), 0);
    check_val("ack_sat", 32'(cfg_ack_tgl), 32'(exp_ack));
    check_val("h_sat", h_info_o, 32'h5555_6666);
    check_val("blank_sat", 32'(blank_o), 1);

    // Reset while a request is pending
    frame(262);
    frame(262);
    check_val("blank_post_sat", 32'(blank_o), 32'(blank_exp(1'b0, 1'b0)));
    toggle_req();
    lines(20);
    check_val("ack_pend", 32'(cfg_ack_tgl), 32'(exp_ack));
    reset_n = 1'b0;
    @(negedge PCLK_in);
    exp_ack = 1'b0;
    check_val("mid_rst_ack", 32'(cfg_ack_tgl), 0);
    check_val("mid_rst_blank", 32'(blank_o), 1);
    check_val("mid_rst_h", h_info_o, 0);
    check_val("mid_rst_v", v_info_o, 0);
    check_val("mid_rst_lines", 32'(lines_meas), 0);
    check_val("mid_rst_stable", 32'(frame_stable), 0);
    reset_n = 1'b1;
    @(negedge PCLK_in);
    frame(262);
    check_val("ack_after_rst", 32'(cfg_ack_tgl), 32'(exp_ack));
    check_val("blank_after_rst", 32'(blank_o), 1);
    check_val("h_after_rst", h_info_o, 0);
    check_val("lines_after_rst", 32'(lines_meas), 262);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_cfg_sched.md
Name: frame_cfg_sched

Overview:
- Sits in the PCLK_in domain between the CPU config PIOs (h_info, v_info, hscale_info) and the scanconverter.
- Applies a new configuration set atomically, only on an input frame boundary, then blanks output for a fixed number of frames while the scanconverter settles.
- Measures input lines per frame and reports frame stability back to the CPU.

Parameters:
- FRAME_MUTE, 2: number of VSYNC edges that blank_o stays high after a config apply (1..15).
- STABLE_FRAMES, 4: number of consecutive matching frames required before frame_stable is asserted (1..15).
- LINE_TOL, 1: maximum line-count difference between consecutive frames that still counts as a match.

Ports:
- PCLK_in  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- HSYNC_in  in  1  latched input hsync, active-low.
- VSYNC_in  in  1  latched input vsync, active-low.
- cfg_req_tgl  in  1  clk27-domain request toggle; synchronized internally.
- h_info_new  in  32  new horizontal config; quasi-static while a request is outstanding.
- v_info_new  in  32  new vertical config; quasi-static while a request is outstanding.
- hscale_new  in  32  new hscale config; quasi-static while a request is outstanding.
- cfg_ack_tgl  out  1  toggles once per applied request.
- h_info_o  out  32  applied horizontal config, to the scanconverter.
- v_info_o  out  32  applied vertical config, to the scanconverter.
- hscale_o  out  32  applied hscale config, to the scanconverter.
- blank_o  out  1  force output blanking.
- lines_meas  out  11  lines counted in the last complete frame.
- frame_stable  out  1  input timing is stable.

Behaviour:
- Reset values: all *_o buses 0, blank_o 1, cfg_ack_tgl 0, lines_meas 0, frame_stable 0, FSM in IDLE.
- Synchronization and edge detection:
  - cfg_req_tgl passes through a 2-FF synchronizer plus a third register for edge detection.
  - req_evt = synced XOR delayed, one cycle wide; 3-cycle latency from input toggle to req_evt.
  - vs_evt = VSYNC_in falling edge, hs_evt = HSYNC_in falling edge, each via a one-register compare.
- FSM states:
  - IDLE: on req_evt go to PEND. This holds even if vs_evt occurs in the same cycle; that edge is not used.
  - PEND: on vs_evt go to APPLY. Further req_evt events are absorbed, with no extra ack.
  - APPLY (1 cycle): load h_info_o, v_info_o and hscale_o from the *_new buses; toggle cfg_ack_tgl; blank_o=1; mute_cnt=0; go to MUTE.
  - MUTE: blank_o=1. On each vs_evt, mute_cnt++. When mute_cnt reaches FRAME_MUTE, clear blank_o and go to IDLE, or to PEND if a req_evt arrived during MUTE (latched in a pending flag).
- Exactly one ack per apply. Outputs never change mid-frame.
- blank_o initial behaviour: blank_o stays 1 from reset until the first apply+mute completes.
- Line counter:
  - 11-bit counter of hs_evt, saturating at 2047.
  - On vs_evt: lines_meas <= count; count <= hs_evt ? 1 : 0. A simultaneous hsync edge belongs to the new frame.
- Stability:
  - Evaluated on each vs_evt by comparing the new count with the previous lines_meas.
  - If |diff| <= LINE_TOL, count < 2047 and the previous value is nonzero, stab_cnt++ (saturating at STABLE_FRAMES). Otherwise stab_cnt=0.
  - frame_stable = (stab_cnt == STABLE_FRAMES), registered on the cycle after vs_evt.
- Reset mid-operation: immediate return to reset values. A pending request is dropped and no ack is produced. Because cfg_ack_tgl is reset to 0, the CPU must re-issue after reset_n deasserts.

Optional Feature:
- Macro: FRAME_CFG_UNSTABLE_BLANK_EN.
- Defined: blank_o = FSM blank OR ~frame_stable. Output is muted whenever input timing is unstable.
- Not defined: blank_o is driven by the FSM only; frame_stable is status output only.

Test Plan:
- Reset, then 5 frames of 262 lines with no request -> blank_o=1 throughout, lines_meas=262, frame_stable=1 after the 5th vs_evt.
- After lock, toggle cfg_req_tgl with h_info_new=32'h0355_3E3C mid-frame -> h_info_o is unchanged until the next vs_evt, loads on the following cycle, cfg_ack_tgl toggles once, blank_o=1 for exactly 2 vs_evt, then 0.
- Toggle cfg_req_tgl twice during MUTE -> a single further apply at the first vs_evt after MUTE ends, one extra ack toggle.
- Alternate frames of 262/264 lines -> frame_stable=0 and stab_cnt held at 0. Then frames of 262/263 -> frame_stable=1 after 4 matches (LINE_TOL=1).
- No VSYNC for 3000 lines -> count saturates at 2047, lines_meas=2047, frame_stable=0. A request stays in PEND with no ack until a vsync edge.
- Assert reset_n in PEND -> no ack toggle, blank_o=1, outputs 0. With FRAME_CFG_UNSTABLE_BLANK_EN, a line-count jump forces blank_o=1 on the next cycle after vs_evt.
